// File: rtl/store_buffer_if.sv
// store_buffer_if: store, load-query and memory write signals of the store buffer
interface store_buffer_if;
    logic        st_valid;
    logic        st_ready;
    logic [29:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_mask;
    logic        ld_check;
    logic [29:0] ld_addr;
    logic        ld_hazard;
    logic        mem_valid;
    logic        mem_ready;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    modport master (
        output st_valid, st_addr, st_data, st_mask, ld_check, ld_addr, mem_ready,
        input  st_ready, ld_hazard, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
    modport slave (
        input  st_valid, st_addr, st_data, st_mask, ld_check, ld_addr, mem_ready,
        output st_ready, ld_hazard, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the store encoder and the data-memory write port
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    store_buffer_if.slave          sb,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       strb_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nxt;
    logic [3:0]       st_strb;
    logic             st_fire;
    logic             enq;
    logic             deq;
    logic             hit;

    assign sb.st_ready  = !full;
    assign st_fire      = sb.st_valid && sb.st_ready;
    assign enq          = st_fire && (|sb.st_mask);
    assign sb.mem_valid = !empty;
    assign deq          = sb.mem_valid && sb.mem_ready;
    assign sb.mem_addr  = addr_q[rd_ptr];
    assign sb.mem_wdata = data_q[rd_ptr];
    assign sb.mem_wstrb = strb_q[rd_ptr];
    assign count_nxt    = count + (AW+1)'(enq) - (AW+1)'(deq);
    assign sb.ld_hazard = sb.ld_check && hit;

    // a byte lane is written when any bit of its mask byte is set
    always_comb begin
        st_strb = '0;
        for (int i = 0; i < 4; i++) st_strb[i] = |sb.st_mask[8*i +: 8];
    end

    // same-word match against every occupied entry plus the store entering this cycle
    always_comb begin
        hit = enq && (sb.st_addr == sb.ld_addr);
        for (int i = 0; i < DEPTH; i++) hit = hit || (vld_q[i] && (addr_q[i] == sb.ld_addr));
    end

    // occupancy, pointers and per-entry valid bits; full/empty derive from the count
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld_q  <= '0;
        end else begin
            count <= count_nxt;
            empty <= count_nxt == '0;
            full  <= count_nxt == (AW+1)'(DEPTH);
            if (enq) begin
                wr_ptr         <= wr_ptr + AW'(1);
                vld_q[wr_ptr]  <= 1'b1;
            end
            if (deq) begin
                rd_ptr         <= rd_ptr + AW'(1);
                vld_q[rd_ptr]  <= 1'b0;
            end
        end
    end

    // entry payload: data pre-masked so disabled lanes always read as zero
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr] <= sb.st_addr;
            data_q[wr_ptr] <= sb.st_data & sb.st_mask;
            strb_q[wr_ptr] <= st_strb;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a queue scoreboard checked by an independent memory-side monitor
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] count;
    logic       empty;
    logic       full;
    int         checks = 0;
    int         errors = 0;
    logic [65:0] sb_q[$];

    store_buffer_if sbi();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbi.slave),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic store(input logic [29:0] a, input logic [31:0] d, input logic [31:0] m,
                         input logic [31:0] exp_d, input logic [3:0] exp_s);
        bit done = 0;
        sbi.st_valid = 1'b1;
        sbi.st_addr  = a;
        sbi.st_data  = d;
        sbi.st_mask  = m;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (sbi.st_ready) begin
                done = 1;
                if (m != 0) sb_q.push_back({a, exp_d, exp_s});
            end
            tick();
        end
        if (!done) chk("store_timeout", 32'd1, 32'd0);
        sbi.st_valid = 1'b0;
    endtask

    // memory-side monitor: every accepted write must match the oldest expected store
    always @(negedge clk) begin
        if (!reset && sbi.mem_valid && sbi.mem_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected: got addr 0x%0h data 0x%0h strb 0x%0h expected no write",
                         sbi.mem_addr, sbi.mem_wdata, sbi.mem_wstrb);
            end else begin
                logic [65:0] e;
                e = sb_q.pop_front();
                if ({sbi.mem_addr, sbi.mem_wdata, sbi.mem_wstrb} !== e) begin
                    errors++;
                    $display("FAIL mem_write: got addr 0x%0h data 0x%0h strb 0x%0h expected addr 0x%0h data 0x%0h strb 0x%0h",
                             sbi.mem_addr, sbi.mem_wdata, sbi.mem_wstrb, e[65:36], e[35:4], e[3:0]);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        sbi.st_valid  = 1'b0;
        sbi.st_addr   = '0;
        sbi.st_data   = '0;
        sbi.st_mask   = '0;
        sbi.ld_check  = 1'b1;
        sbi.ld_addr   = '0;
        sbi.mem_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_mem_valid", 32'(sbi.mem_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_st_ready", 32'(sbi.st_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_hazard", 32'(sbi.ld_hazard), 32'd0);
        sbi.ld_check = 1'b0;

        // byte store to lane 1, visible the very next cycle
        store(30'h10, 32'h0000_ff00, 32'h0000_ff00, 32'h0000_ff00, 4'b0010);
        chk("t1_mem_valid", 32'(sbi.mem_valid), 32'd1);
        chk("t1_mem_addr", 32'(sbi.mem_addr), 32'h10);
        chk("t1_mem_wstrb", 32'(sbi.mem_wstrb), 32'b0010);
        sbi.mem_ready = 1'b1;
        tick();
        sbi.mem_ready = 1'b0;
        chk("t1_empty", 32'(empty), 32'd1);

        // fill with memory stalled, fifth store refused, then drain in order
        for (int i = 0; i < 4; i++)
            store(30'h40 + 30'(i), 32'hA0A0_0000 + 32'(i), 32'hffff_ffff, 32'hA0A0_0000 + 32'(i), 4'hf);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_st_ready", 32'(sbi.st_ready), 32'd0);
        chk("t2_count4", 32'(count), 32'd4);
        sbi.st_valid = 1'b1;
        sbi.st_addr  = 30'h44;
        sbi.st_data  = 32'hdead_beef;
        sbi.st_mask  = 32'hffff_ffff;
        tick();
        sbi.st_valid = 1'b0;
        chk("t2_stall_count", 32'(count), 32'd4);
        sbi.mem_ready = 1'b1;
        repeat (4) tick();
        sbi.mem_ready = 1'b0;
        chk("t2_empty", 32'(empty), 32'd1);
        chk("t2_order", 32'(sb_q.size()), 32'd0);

        // full plus simultaneous store: dequeue only, then enqueue with dequeue
        for (int i = 0; i < 4; i++)
            store(30'h50 + 30'(i), 32'h0000_00b0 + 32'(i), 32'h0000_00ff, 32'h0000_00b0 + 32'(i), 4'b0001);
        sbi.st_valid  = 1'b1;
        sbi.st_addr   = 30'h55;
        sbi.st_data   = 32'h1234_5678;
        sbi.st_mask   = 32'hff00_00ff;
        sbi.mem_ready = 1'b1;
        tick();
        chk("t3_count3", 32'(count), 32'd3);
        chk("t3_st_ready", 32'(sbi.st_ready), 32'd1);
        sb_q.push_back({30'h55, 32'h1200_0078, 4'b1001});
        tick();
        sbi.st_valid  = 1'b0;
        sbi.mem_ready = 1'b0;
        chk("t3_count_stays", 32'(count), 32'd3);
        sbi.mem_ready = 1'b1;
        repeat (3) tick();
        sbi.mem_ready = 1'b0;
        chk("t3_empty", 32'(empty), 32'd1);

        // load hazard against pending and incoming stores
        store(30'h20, 32'habcd_1234, 32'hffff_0000, 32'habcd_0000, 4'b1100);
        sbi.ld_check = 1'b1;
        sbi.ld_addr  = 30'h20;
        #1 chk("t4_hit", 32'(sbi.ld_hazard), 32'd1);
        sbi.ld_addr = 30'h21;
        #1 chk("t4_miss", 32'(sbi.ld_hazard), 32'd0);
        sbi.st_valid = 1'b1;
        sbi.st_addr  = 30'h21;
        sbi.st_mask  = 32'h0000_00ff;
        #1 chk("t4_incoming_hit", 32'(sbi.ld_hazard), 32'd1);
        sbi.st_mask = 32'h0;
        #1 chk("t4_incoming_zero_mask", 32'(sbi.ld_hazard), 32'd0);
        sbi.st_valid = 1'b0;
        sbi.ld_addr  = 30'h20;
        sbi.ld_check = 1'b0;
        #1 chk("t4_no_check", 32'(sbi.ld_hazard), 32'd0);
        sbi.ld_check  = 1'b1;
        sbi.mem_ready = 1'b1;
        #1 chk("t4_head_deq_hit", 32'(sbi.ld_hazard), 32'd1);
        tick();
        sbi.mem_ready = 1'b0;
        chk("t4_after_drain", 32'(sbi.ld_hazard), 32'd0);
        sbi.ld_check = 1'b0;

        // zero-mask store handshakes but never reaches memory
        store(30'h30, 32'h1234_5678, 32'h0, 32'h0, 4'h0);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_mem_valid", 32'(sbi.mem_valid), 32'd0);

        // reset with a stalled head discards everything
        for (int i = 0; i < 3; i++)
            store(30'h60 + 30'(i), 32'h0000_0c00 + 32'(i), 32'hffff_ffff, 32'h0000_0c00 + 32'(i), 4'hf);
        chk("t6_pre_count", 32'(count), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        chk("t6_mem_valid", 32'(sbi.mem_valid), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);

        // pointer wrap with 2*DEPTH+1 stores while memory drains
        sbi.mem_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 1; i++)
            store(30'h100 + 30'(i), 32'h5a00_0000 + 32'(i), 32'hff00_ffff, 32'h5a00_0000 + 32'(i), 4'b1011);
        for (int n = 0; n < 20 && !empty; n++) tick();
        sbi.mem_ready = 1'b0;
        chk("t6_wrap_empty", 32'(empty), 32'd1);
        chk("t6_wrap_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
